// File: rtl/fetcher_if.sv
// Fetch-stage bus bundle: memory request/response, decode handoff and ROB redirect.
// The master side belongs to the fetcher; the slave side is the memory/decode/ROB environment.
interface fetcher_if;
    logic        out_mem_req;
    logic [31:0] out_mem_addr;
    logic        in_mem_valid;
    logic [31:0] in_mem_inst;
    logic        in_stall;
    logic        in_flush;
    logic [31:0] in_flush_pc;
    logic        out_decode_ena;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_predicted_taken;

    modport master (
        output out_mem_req, out_mem_addr, out_decode_ena, out_inst, out_pc, out_predicted_taken,
        input  in_mem_valid, in_mem_inst, in_stall, in_flush, in_flush_pc
    );

    modport slave (
        input  out_mem_req, out_mem_addr, out_decode_ena, out_inst, out_pc, out_predicted_taken,
        output in_mem_valid, in_mem_inst, in_stall, in_flush, in_flush_pc
    );
endinterface

// File: rtl/fetcher.sv
// Instruction fetch stage: one-outstanding word reads, static branch prediction,
// small instruction queue feeding decode, and ROB flush redirect.
module fetcher #(
    parameter int unsigned IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic       clk,
    input logic       rst,
    fetcher_if.master io_bus
);
    localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t              r_state;
    logic [31:0]         r_pc;
    logic [31:0]         r_addr;
    logic                r_req;
    logic [31:0]         r_q_inst [IQ_DEPTH];
    logic [31:0]         r_q_pc   [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] r_q_pred;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;

    logic [31:0] w_inst;
    logic [31:0] w_j_imm;
    logic [31:0] w_b_imm;
    logic [31:0] w_next_pc;
    logic        w_pred;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_room_idle;
    logic        w_room_push;

    // Static predictor plus queue control for the current cycle
    always_comb begin
        w_inst    = io_bus.in_mem_inst;
        w_j_imm   = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
        w_b_imm   = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
        w_pred    = 1'b0;
        w_next_pc = r_pc + 32'd4;
        if (w_inst[6:0] == OP_JAL) begin
            w_pred    = 1'b1;
            w_next_pc = r_pc + w_j_imm;
        end else if (w_inst[6:0] == OP_BRANCH && w_inst[31]) begin
            w_pred    = 1'b1;
            w_next_pc = r_pc + w_b_imm;
        end
        w_empty     = (r_count == '0);
        w_pop       = !w_empty && !io_bus.in_stall && !io_bus.in_flush;
        w_push      = (r_state == S_WAIT) && io_bus.in_mem_valid && !io_bus.in_flush;
        // A same-cycle pop never creates room for the issue decision
        w_room_idle = r_count < CNT_W'(IQ_DEPTH);
        w_room_push = (r_count + CNT_W'(1)) < CNT_W'(IQ_DEPTH);
    end

    assign io_bus.out_mem_req         = r_req;
    assign io_bus.out_mem_addr        = r_addr;
    assign io_bus.out_decode_ena      = w_pop;
    assign io_bus.out_inst            = r_q_inst[r_head];
    assign io_bus.out_pc              = r_q_pc[r_head];
    assign io_bus.out_predicted_taken = r_q_pred[r_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_addr   <= RESET_PC;
            r_req    <= 1'b0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_q_pred <= '0;
            for (int i = 0; i < int'(IQ_DEPTH); i++) begin
                r_q_inst[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (io_bus.in_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_pc    <= io_bus.in_flush_pc;
            // An in-flight read cannot be cancelled, so its response must be swallowed
            if ((r_state == S_WAIT || r_state == S_DROP) && !io_bus.in_mem_valid) begin
                r_state <= S_DROP;
                r_req   <= 1'b0;
            end else begin
                r_state <= S_WAIT;
                r_req   <= 1'b1;
                r_addr  <= io_bus.in_flush_pc;
            end
        end else begin
            if (w_push) begin
                r_q_inst[r_tail] <= io_bus.in_mem_inst;
                r_q_pc[r_tail]   <= r_pc;
                r_q_pred[r_tail] <= w_pred;
                r_tail           <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_room_idle) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                    end
                end
                S_WAIT: begin
                    if (io_bus.in_mem_valid) begin
                        r_pc <= w_next_pc;
                        if (w_room_push) begin
                            r_state <= S_WAIT;
                            r_req   <= 1'b1;
                            r_addr  <= w_next_pc;
                        end else begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (io_bus.in_mem_valid) begin
                        if (w_room_idle) begin
                            r_state <= S_WAIT;
                            r_req   <= 1'b1;
                            r_addr  <= r_pc;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetcher.sv
// Bench for fetcher: latency-configurable memory responder, queue-based reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_fetcher;
    localparam int unsigned IQ_DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    fetcher_if bus ();

    fetcher #(.IQ_DEPTH(IQ_DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Program memory; unmapped words read as NOP
    logic [31:0] mem [bit [31:0]];
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return NOP;
    endfunction

    // Memory responder: accepts a visible request, answers lat cycles later with a 1-cycle pulse
    int          lat = 2;
    bit          busy = 0;
    int          cnt = 0;
    logic [31:0] busy_addr;
    logic [31:0] req_log [$];
    int          req_cyc [$];
    int          valid_cyc [$];

    always @(posedge clk) begin
        cyc++;
        #1;
        bus.in_mem_valid = 1'b0;
        if (rst) begin
            busy = 0;
        end else if (busy) begin
            cnt--;
            if (cnt == 0) begin
                bus.in_mem_valid = 1'b1;
                bus.in_mem_inst  = mem_read(busy_addr);
                busy = 0;
                valid_cyc.push_back(cyc);
            end
        end else if (bus.out_mem_req) begin
            busy      = 1;
            cnt       = lat;
            busy_addr = bus.out_mem_addr;
            req_log.push_back(busy_addr);
            req_cyc.push_back(cyc);
        end
    end

    // Reference model: queue of fetched entries plus request / drop flags
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        mq [$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_req  = 0;
    bit          m_drop = 0;
    bit          m_ok   = 0;

    function automatic void predict(input logic [31:0] inst, input logic [31:0] pc,
                                    output logic pred, output logic [31:0] nxt);
        int imm;
        pred = 1'b0;
        nxt  = pc + 32'd4;
        if (inst[6:0] == 7'h6F) begin
            imm = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
                  - (inst[31] ? 1048576 : 0);
            pred = 1'b1;
            nxt  = pc + 32'(imm);
        end else if (inst[6:0] == 7'h63 && inst[31]) begin
            imm = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32 + int'(inst[7]) * 2048 - 4096;
            pred = 1'b1;
            nxt  = pc + 32'(imm);
        end
    endfunction

    always @(posedge clk) begin
        int          n;
        bit          pop;
        ent_t        e;
        logic [31:0] nxt;
        if (rst) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_addr = RESET_PC;
            m_req  = 0;
            m_drop = 0;
            m_ok   = 1;
        end else if (m_ok) begin
            n   = mq.size();
            pop = (n > 0) && !bus.in_stall && !bus.in_flush;
            if (bus.in_flush) begin
                mq.delete();
                m_pc = bus.in_flush_pc;
                if ((m_req || m_drop) && !bus.in_mem_valid) begin
                    m_drop = 1;
                    m_req  = 0;
                end else begin
                    m_drop = 0;
                    m_req  = 1;
                    m_addr = m_pc;
                end
            end else begin
                if (pop) void'(mq.pop_front());
                if (m_drop) begin
                    if (bus.in_mem_valid) begin
                        m_drop = 0;
                        m_req  = (n < int'(IQ_DEPTH));
                        m_addr = m_pc;
                    end
                end else if (m_req) begin
                    if (bus.in_mem_valid) begin
                        e.inst = bus.in_mem_inst;
                        e.pc   = m_pc;
                        predict(bus.in_mem_inst, m_pc, e.pred, nxt);
                        mq.push_back(e);
                        m_pc   = nxt;
                        m_req  = (n + 1 < int'(IQ_DEPTH));
                        m_addr = m_pc;
                    end
                end else begin
                    m_req  = (n < int'(IQ_DEPTH));
                    m_addr = m_pc;
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus decode trace for directed checks
    logic [31:0] dec_pc [$];
    logic        dec_pred [$];
    int          dec_cyc [$];

    always @(negedge clk) begin
        logic exp_ena;
        if (m_ok) begin
            exp_ena = (mq.size() > 0) && !bus.in_stall && !bus.in_flush;
            check("decode_ena", 32'(bus.out_decode_ena), 32'(exp_ena));
            if (exp_ena && bus.out_decode_ena) begin
                check("head_inst", bus.out_inst, mq[0].inst);
                check("head_pc", bus.out_pc, mq[0].pc);
                check("head_pred", 32'(bus.out_predicted_taken), 32'(mq[0].pred));
            end
            check("mem_req", 32'(bus.out_mem_req), 32'(m_req));
            if (m_req) check("mem_addr", bus.out_mem_addr, m_addr);
        end
        if (bus.out_decode_ena === 1'b1) begin
            dec_pc.push_back(bus.out_pc);
            dec_pred.push_back(bus.out_predicted_taken);
            dec_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_stall    = 1'b0;
        bus.in_flush    = 1'b0;
        bus.in_flush_pc = '0;
        tick();
        tick();
        rst = 1'b0;
        req_log.delete();
        req_cyc.delete();
        valid_cyc.delete();
        dec_pc.delete();
        dec_pred.delete();
        dec_cyc.delete();
    endtask

    task automatic wait_decodes(input int n, input int budget, input string name);
        int k = 0;
        while (dec_pc.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(dec_pc.size() >= n), 32'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pcs [6];
        logic        exp_prd [6];
        logic [31:0] exp_req [7];
        int          n0;
        int          fcyc;
        int          k;

        // Reset values
        rst = 1'b1;
        bus.in_stall    = 1'b0;
        bus.in_flush    = 1'b0;
        bus.in_flush_pc = '0;
        tick();
        tick();
        check("rst_mem_req", 32'(bus.out_mem_req), 32'd0);
        check("rst_mem_addr", bus.out_mem_addr, RESET_PC);
        check("rst_decode_ena", 32'(bus.out_decode_ena), 32'd0);
        check("rst_inst", bus.out_inst, 32'd0);
        check("rst_pc", bus.out_pc, 32'd0);
        check("rst_pred", 32'(bus.out_predicted_taken), 32'd0);

        // Sequential ADDI fetch, latency 2
        mem.delete();
        mem[32'h0] = 32'h00100093;
        mem[32'h4] = 32'h00200113;
        mem[32'h8] = 32'h00300193;
        lat = 2;
        do_reset();
        wait_decodes(3, 40, "seq_timeout");
        for (int i = 0; i < 3; i++) begin
            check("seq_req_addr", req_log[i], 32'(4 * i));
            check("seq_dec_pc", dec_pc[i], 32'(4 * i));
            check("seq_dec_pred", 32'(dec_pred[i]), 32'd0);
            check("seq_latency", 32'(dec_cyc[i]), 32'(valid_cyc[i] + 1));
        end
        check("seq_first_req_cycle", 32'(req_cyc[0] - cyc + 0), 32'(req_cyc[0] - cyc));

        // JAL / backward BEQ / forward BNE program, latency 1
        mem.delete();
        mem[32'h00] = 32'h0100006F;
        mem[32'h10] = 32'h0200006F;
        mem[32'h30] = 32'h0100006F;
        mem[32'h40] = 32'hFE000CE3;
        mem[32'h38] = 32'h00001663;
        exp_pcs = '{32'h0, 32'h10, 32'h30, 32'h40, 32'h38, 32'h3C};
        exp_prd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_req = '{32'h0, 32'h10, 32'h30, 32'h40, 32'h38, 32'h3C, 32'h40};
        lat = 1;
        do_reset();
        wait_decodes(6, 60, "br_timeout");
        tick();
        for (int i = 0; i < 6; i++) begin
            check("br_dec_pc", dec_pc[i], exp_pcs[i]);
            check("br_dec_pred", 32'(dec_pred[i]), 32'(exp_prd[i]));
        end
        for (int i = 0; i < 7; i++) check("br_req_addr", req_log[i], exp_req[i]);

        // Full queue under stall, then drain
        mem.delete();
        lat = 1;
        do_reset();
        bus.in_stall = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        check("full_valids", 32'(valid_cyc.size()), 32'd4);
        check("full_reqs", 32'(req_log.size()), 32'd4);
        check("full_req_low", 32'(bus.out_mem_req), 32'd0);
        check("full_no_decode", 32'(dec_pc.size()), 32'd0);
        bus.in_stall = 1'b0;
        wait_decodes(5, 40, "drain_timeout");
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", dec_pc[i], 32'(4 * i));
            check("drain_cycle", 32'(dec_cyc[i]), 32'(dec_cyc[0] + i));
        end
        check("resume_req", req_log[4], 32'h10);
        check("resume_dec_pc", dec_pc[4], 32'h10);

        // Flush while a request is outstanding: response dropped, no request during drop
        mem.delete();
        mem[32'h0] = 32'h0200006F;
        lat = 4;
        do_reset();
        k = 0;
        while (req_log.size() < 2 && k < 40) begin
            tick();
            k++;
        end
        check("drop_setup_req", req_log[1], 32'h20);
        tick();
        n0 = dec_pc.size();
        fcyc = cyc;
        bus.in_flush    = 1'b1;
        bus.in_flush_pc = 32'h100;
        tick();
        bus.in_flush = 1'b0;
        check("drop_fifo_empty", 32'(bus.out_decode_ena), 32'd0);
        check("drop_req_low", 32'(bus.out_mem_req), 32'd0);
        k = 0;
        while (req_log.size() < 3 && k < 20) begin
            tick();
            k++;
        end
        check("drop_valid_cycle", 32'(valid_cyc[1]), 32'(fcyc + 3));
        check("drop_next_req", req_log[2], 32'h100);
        check("drop_next_req_cycle", 32'(req_cyc[2]), 32'(valid_cyc[1] + 1));
        wait_decodes(n0 + 1, 30, "drop_timeout");
        check("drop_first_dec", dec_pc[n0], 32'h100);

        // Flush coincident with a response while the queue holds entries
        mem.delete();
        lat = 2;
        do_reset();
        bus.in_stall = 1'b1;
        k = 0;
        while (valid_cyc.size() < 2 && k < 30) begin
            tick();
            k++;
        end
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.in_mem_valid !== 1'b1 && k < 10);
        check("coinc_valid_seen", 32'(bus.in_mem_valid), 32'd1);
        bus.in_flush    = 1'b1;
        bus.in_flush_pc = 32'h200;
        bus.in_stall    = 1'b0;
        #1;
        check("coinc_ena_low", 32'(bus.out_decode_ena), 32'd0);
        tick();
        bus.in_flush = 1'b0;
        check("coinc_req", 32'(bus.out_mem_req), 32'd1);
        check("coinc_addr", bus.out_mem_addr, 32'h200);
        wait_decodes(1, 20, "coinc_timeout");
        check("coinc_first_dec", dec_pc[0], 32'h200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
